ex_issue_ctrl: RTL
==================

// Module: ex_issue_ctrl
// PURPOSE
//  Execute-stage sequencer for the pipelined CPU; it sits on the driving side of the ALU.
//  Accepts one decoded op from ID/EX using a valid/ready handshake, then holds the ALU operand and control ports stable.
//  MUL ops get a multi-cycle hold window.
//  The unit registers the ALU result into an EX/MEM output slot (valid/ready), or resolves a branch.
// PARAMETERS
//  MUL_LAT  4  cycles the ALU inputs are held for ctrl 4'b1000 (MUL); legal range 2..15
// PORTS
//  clk_i           in   1   clock; all state updates on the rising edge
//  rst_i           in   1   reset; synchronous, active-high
//  id_valid_i      in   1   ID presents an op
//  id_ready_o      out  1   EX accepts the op this cycle
//  id_src1_i       in   32  operand 1 (rs value)
//  id_src2_i       in   32  operand 2 (rt value or immediate)
//  id_shamt_i      in   5   shift amount
//  id_ctrl_i       in   4   ALU control code
//  id_rs_i         in   5   rs index (used only with EX_FWD_EN)
//  id_rt_i         in   5   rt index (used only with EX_FWD_EN)
//  id_rd_i         in   5   destination register
//  id_regwrite_i   in   1   op writes rd
//  id_branch_i     in   1   op is a branch; ctrl is one of BGT 1001, BEQ 1011, BNE 1110, BGE 1010
//  id_br_target_i  in   32  branch target address
//  alu_src1_o      out  32  to ALU src1_i
//  alu_src2_o      out  32  to ALU src2_i
//  alu_shamt_o     out  5   to ALU shamt
//  alu_ctrl_o      out  4   to ALU ctrl_i
//  alu_result_i    in   32  from ALU result_o
//  alu_zero_i      in   1   from ALU zero_o
//  mem_valid_o     out  1   output slot holds a result
//  mem_ready_i     in   1   MEM consumes the slot
//  mem_result_o    out  32  registered ALU result
//  mem_rd_o        out  5   registered destination
//  mem_regwrite_o  out  1   registered regwrite
//  br_taken_o      out  1   one-cycle pulse: branch taken
//  br_target_o     out  32  target; valid while br_taken_o=1
// BEHAVIOUR
//  Reset: state=IDLE, MUL counter=0, every output and ALU-drive register = 0.
//   Reset aborts any op in flight, including one in MULW or OUT; that op is dropped.
//  FSM states IDLE, EXEC, MULW, OUT.
//   IDLE: id_ready_o=1. When id_valid_i=1, operands, ctrl, rd, regwrite, branch and target are latched.
//     ctrl==MUL -> MULW with count=MUL_LAT-1; otherwise -> EXEC.
//   EXEC: ALU ports are driven from the latched values (1 cycle).
//     Branch op: br_taken_o<=~alu_zero_i, br_target_o<=latched target; -> IDLE. No output slot is written.
//     Other op: mem_result_o<=alu_result_i, mem_rd_o, mem_regwrite_o, mem_valid_o<=1; -> OUT.
//   MULW: ALU ports are held constant; count decrements each cycle.
//     At count==0, result capture is identical to the EXEC non-branch path; -> OUT.
//   OUT: mem_valid_o=1, and all mem_* outputs are stable until mem_ready_i=1.
//     id_ready_o=mem_ready_i (combinational). If mem_ready_i=1 and id_valid_i=1, the new op is latched in the same cycle
//     (back-to-back, no bubble) and mem_valid_o drops. If mem_ready_i=1 and id_valid_i=0, -> IDLE with mem_valid_o<=0.
//  Latency from the accept edge to mem_valid_o=1: non-MUL 2 edges; MUL MUL_LAT+1 edges.
//  Branch: br_taken_o pulses on the 2nd edge after accept and clears on the next edge.
//  id_ready_o=0 in EXEC and MULW; ID must hold its inputs stable while id_valid_i=1 and id_ready_o=0.
//  Widths: results are 32 bits; the MUL product is truncated to its low 32 bits by the ALU.
// CONFIGURATION
//  EX_FWD_EN defined: at accept, a latched operand is replaced by mem_result_o when all of the following hold:
//   mem_valid_o=1, mem_regwrite_o=1, mem_rd_o!=0, and id_rs_i==mem_rd_o (src1) or id_rt_i==mem_rd_o (src2).
//   src2 is forwarded only when id_branch_i=1 or id_ctrl_i is in {0000, 0001, 0010, 0110, 0111, 0011, 1000}.
//  EX_FWD_EN undefined: id_rs_i and id_rt_i are ignored; operands are latched as presented.
// TESTING
//  Reset check: rst_i high for 2 cycles, even mid-MULW -> all outputs 0, id_ready_o=1 the next cycle.
//  ADD 5+7, mem_ready_i=1 -> mem_valid_o=1 two edges after accept, mem_result_o=12, held exactly 1 cycle.
//  MUL 3*4, MUL_LAT=4 -> alu_* ports stable for 4 cycles, id_ready_o=0 for those cycles, mem_result_o=12 at edge 5.
//  BEQ with 9,9 -> br_taken_o=1 for 1 cycle, br_target_o matches the latched target; BNE with 9,9 -> br_taken_o=0; mem_valid_o stays 0 in both.
//  OUT with mem_ready_i=0 for 3 cycles, then 1 with id_valid_i=1 -> slot held, new op accepted on the release edge, no bubble.
//  EX_FWD_EN: ADD rd=3 result 12 in OUT; next op with rs=3 and src1_i=0 -> result uses 12; repeat with rd=0 -> no forwarding.

Source files
------------

// File: rtl/ex_issue_ctrl_if.sv
// Signal bundle between ex_issue_ctrl and its ID, ALU and MEM neighbours.
// slave is the execute unit's view and master is the environment's view.
interface ex_issue_ctrl_if;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [31:0] id_src1_i;
  logic [31:0] id_src2_i;
  logic [4:0]  id_shamt_i;
  logic [3:0]  id_ctrl_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_branch_i;
  logic [31:0] id_br_target_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [4:0]  alu_shamt_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_result_o;
  logic [4:0]  mem_rd_o;
  logic        mem_regwrite_o;
  logic        br_taken_o;
  logic [31:0] br_target_o;

  modport slave (
    input  id_valid_i, id_src1_i, id_src2_i, id_shamt_i, id_ctrl_i, id_rs_i, id_rt_i,
           id_rd_i, id_regwrite_i, id_branch_i, id_br_target_i,
           alu_result_i, alu_zero_i, mem_ready_i,
    output id_ready_o, alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o,
           mem_valid_o, mem_result_o, mem_rd_o, mem_regwrite_o, br_taken_o, br_target_o
  );

  modport master (
    output id_valid_i, id_src1_i, id_src2_i, id_shamt_i, id_ctrl_i, id_rs_i, id_rt_i,
           id_rd_i, id_regwrite_i, id_branch_i, id_br_target_i,
           alu_result_i, alu_zero_i, mem_ready_i,
    input  id_ready_o, alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o,
           mem_valid_o, mem_result_o, mem_rd_o, mem_regwrite_o, br_taken_o, br_target_o
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue sequencer: latches one ID op, holds the ALU inputs, then registers the result or resolves a branch.
// Define EX_FWD_EN to forward the EX/MEM slot result into operands at accept time.
module ex_issue_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  ex_issue_ctrl_if.slave bus
);
  localparam logic [3:0] CTRL_MUL = 4'b1000;
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MULW, OUT} state_t;
  state_t r_state, w_nextState;

  logic [31:0] r_src1, r_src2, r_target, r_memResult, r_brTarget;
  logic [4:0]  r_shamt, r_rd, r_memRd;
  logic [3:0]  r_ctrl, r_mulCount;
  logic        r_regwrite, r_branch, r_memValid, r_memRegwrite, r_brTaken;
  logic        w_idReady, w_accept, w_capture, w_resolve, w_newIsMul;
  logic [31:0] w_src1, w_src2;

  assign w_newIsMul = (bus.id_ctrl_i == CTRL_MUL);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // OUT accepts a new op on the same edge the slot drains, so back-to-back issue has no bubble.
  always_comb begin
    w_nextState = r_state;
    w_idReady   = 1'b0;
    w_capture   = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      IDLE: begin
        w_idReady = 1'b1;
        if (bus.id_valid_i) w_nextState = w_newIsMul ? MULW : EXEC;
      end
      EXEC: begin
        if (r_branch) begin
          w_resolve   = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_capture   = 1'b1;
          w_nextState = OUT;
        end
      end
      MULW: begin
        if (r_mulCount == 4'd0) begin
          w_capture   = 1'b1;
          w_nextState = OUT;
        end
      end
      OUT: begin
        w_idReady = bus.mem_ready_i;
        if (bus.mem_ready_i)
          w_nextState = bus.id_valid_i ? (w_newIsMul ? MULW : EXEC) : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept = w_idReady & bus.id_valid_i;

`ifdef EX_FWD_EN
  logic w_fwdOk, w_src2Eligible;
  assign w_fwdOk        = r_memValid & r_memRegwrite & (r_memRd != 5'd0);
  assign w_src2Eligible = bus.id_branch_i |
                          (bus.id_ctrl_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                                 4'b0111, 4'b0011, 4'b1000});
  assign w_src1 = (w_fwdOk && (bus.id_rs_i == r_memRd)) ? r_memResult : bus.id_src1_i;
  assign w_src2 = (w_fwdOk && w_src2Eligible && (bus.id_rt_i == r_memRd)) ? r_memResult : bus.id_src2_i;
`else
  logic [9:0] w_unusedIdx;
  assign w_unusedIdx = {bus.id_rs_i, bus.id_rt_i};
  assign w_src1      = bus.id_src1_i;
  assign w_src2      = bus.id_src2_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_src1        <= '0;
      r_src2        <= '0;
      r_shamt       <= '0;
      r_ctrl        <= '0;
      r_rd          <= '0;
      r_regwrite    <= 1'b0;
      r_branch      <= 1'b0;
      r_target      <= '0;
      r_mulCount    <= '0;
      r_memValid    <= 1'b0;
      r_memResult   <= '0;
      r_memRd       <= '0;
      r_memRegwrite <= 1'b0;
      r_brTaken     <= 1'b0;
      r_brTarget    <= '0;
    end else begin
      r_brTaken <= 1'b0;
      if (w_accept) begin
        r_src1     <= w_src1;
        r_src2     <= w_src2;
        r_shamt    <= bus.id_shamt_i;
        r_ctrl     <= bus.id_ctrl_i;
        r_rd       <= bus.id_rd_i;
        r_regwrite <= bus.id_regwrite_i;
        r_branch   <= bus.id_branch_i;
        r_target   <= bus.id_br_target_i;
        r_mulCount <= MUL_INIT;
      end else if (r_state == MULW && r_mulCount != 4'd0) begin
        r_mulCount <= r_mulCount - 4'd1;
      end
      if (w_capture) begin
        r_memValid    <= 1'b1;
        r_memResult   <= bus.alu_result_i;
        r_memRd       <= r_rd;
        r_memRegwrite <= r_regwrite;
      end else if (r_state == OUT && bus.mem_ready_i) begin
        r_memValid <= 1'b0;
      end
      if (w_resolve) begin
        r_brTaken  <= ~bus.alu_zero_i;
        r_brTarget <= r_target;
      end
    end
  end

  assign bus.id_ready_o     = w_idReady;
  assign bus.alu_src1_o     = r_src1;
  assign bus.alu_src2_o     = r_src2;
  assign bus.alu_shamt_o    = r_shamt;
  assign bus.alu_ctrl_o     = r_ctrl;
  assign bus.mem_valid_o    = r_memValid;
  assign bus.mem_result_o   = r_memResult;
  assign bus.mem_rd_o       = r_memRd;
  assign bus.mem_regwrite_o = r_memRegwrite;
  assign bus.br_taken_o     = r_brTaken;
  assign bus.br_target_o    = r_brTarget;
endmodule
